// File: rtl/ascon_pack.sv
// Shared types, constants and helpers for the Ascon permutation core.
package ascon_pack;

  localparam int unsigned ROUND_MAX = 12;
  localparam int unsigned STATE_W   = 320;
  localparam int unsigned WORD_W    = 64;

  typedef logic [STATE_W-1:0] type_state;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_state_t;

  // Round constants, indexed by absolute round number 0..11.
  localparam logic [0:ROUND_MAX-1][7:0] C = {
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] v, input int unsigned k);
    return (v >> k) | (v << (WORD_W - k));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round; passes the state through when disabled.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state,
  input  logic [3:0] round,
  input  logic       enable,
  output type_state  result
);

  logic [7:0] rc;
  type_state  added;
  type_state  subbed;
  type_state  diffused;

  // Out-of-range indices only occur on disabled slots; force a zero constant there.
  assign rc    = (round < 4'(ROUND_MAX)) ? C[round] : 8'h00;
  assign added = state ^ {184'h0, rc, 128'h0};

  substitution u_sub (
    .state  (added),
    .result (subbed)
  );

  diffusion_layer u_dif (
    .state  (subbed),
    .result (diffused)
  );

  assign result = enable ? diffused : state;

endmodule

// File: rtl/diffusion_layer.sv
// Ascon linear diffusion: each word XORed with two rotations of itself.
module diffusion_layer
  import ascon_pack::*;
(
  input  type_state state,
  output type_state result
);

  logic [WORD_W-1:0] x0, x1, x2, x3, x4;

  assign x0 = state[319:256];
  assign x1 = state[255:192];
  assign x2 = state[191:128];
  assign x3 = state[127:64];
  assign x4 = state[63:0];

  assign result = {
    x0 ^ ror64(x0, 19) ^ ror64(x0, 28),
    x1 ^ ror64(x1, 61) ^ ror64(x1, 39),
    x2 ^ ror64(x2, 1)  ^ ror64(x2, 6),
    x3 ^ ror64(x3, 10) ^ ror64(x3, 17),
    x4 ^ ror64(x4, 7)  ^ ror64(x4, 41)
  };

endmodule

// File: rtl/substitution.sv
// Bitsliced 5-bit Ascon S-box applied to all 64 columns of the state.
module substitution
  import ascon_pack::*;
(
  input  type_state state,
  output type_state result
);

  logic [WORD_W-1:0] x0, x1, x2, x3, x4;
  logic [WORD_W-1:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state[319:256];
    x1 = state[255:192];
    x2 = state[191:128];
    x3 = state[127:64];
    x4 = state[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    result = {x0, x1, x2, x3, x4};
  end

endmodule

// File: rtl/permutation_unrolled.sv
// Iterative Ascon p^n engine computing UNROLL rounds per clock cycle.
module permutation_unrolled
  import ascon_pack::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  input  logic       ack_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       valid_o,
  output type_state  state_o,
  output logic       err_o
);

  fsm_state_t fsm_q, fsm_d;
  logic [3:0] r_q, r_d;
  type_state  state_q, state_d;
  logic       err_q, err_d;
  logic [4:0] r_sum;
  type_state  chain [0:UNROLL];

  assign chain[0] = state_q;
  assign r_sum    = 5'(r_q) + 5'(UNROLL);

  // Chain of round slots; slot k handles absolute round r+k while it is <= 11.
  for (genvar k = 0; k < UNROLL; k++) begin : g_slot
    logic [4:0] idx;
    assign idx = 5'(r_q) + 5'(k);
    ascon_round u_round (
      .state  (chain[k]),
      .round  (4'(idx)),
      .enable (idx <= 5'(ROUND_MAX - 1)),
      .result (chain[k+1])
    );
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      r_q     <= 4'd0;
      state_q <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      r_q     <= r_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    r_d     = r_q;
    state_d = state_q;
    err_d   = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          if (rounds_i >= 4'd1 && rounds_i <= 4'(ROUND_MAX)) begin
            state_d = state_i;
            r_d     = 4'(ROUND_MAX) - rounds_i;
            fsm_d   = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        state_d = chain[UNROLL];
        if (r_sum >= 5'(ROUND_MAX)) begin
          r_d   = 4'(ROUND_MAX);
          fsm_d = DONE;
        end else begin
          r_d = r_sum[3:0];
        end
      end
      DONE: begin
        if (ack_i) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign ready_o = (fsm_q == IDLE);
  assign busy_o  = (fsm_q == RUN);
  assign valid_o = (fsm_q == DONE);
  assign state_o = state_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_permutation_unrolled.sv
// Bench for permutation_unrolled at UNROLL = 1, 3 and 4 against a table-driven Ascon model.
module tb_permutation_unrolled;

  localparam logic [0:31][4:0] SBOX = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam logic [0:11][7:0] RC = {
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };
  localparam logic [319:0] VEC = {
    64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
    64'h0000000000000000, 64'h0000000000000000
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         ack = 1'b0;
  logic [3:0]   rounds = 4'd0;
  logic [319:0] sin = '0;
  logic [2:0]   ready, busy, valid, err;
  logic [319:0] so [3];
  logic [319:0] held [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  permutation_unrolled #(.UNROLL(1)) u_dut1 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .rounds_i(rounds), .state_i(sin),
    .ack_i(ack), .ready_o(ready[0]), .busy_o(busy[0]), .valid_o(valid[0]),
    .state_o(so[0]), .err_o(err[0]));
  permutation_unrolled #(.UNROLL(3)) u_dut3 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .rounds_i(rounds), .state_i(sin),
    .ack_i(ack), .ready_o(ready[1]), .busy_o(busy[1]), .valid_o(valid[1]),
    .state_o(so[1]), .err_o(err[1]));
  permutation_unrolled #(.UNROLL(4)) u_dut4 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .rounds_i(rounds), .state_i(sin),
    .ack_i(ack), .ready_o(ready[2]), .busy_o(busy[2]), .valid_o(valid[2]),
    .state_o(so[2]), .err_o(err[2]));

  function automatic int un(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int k);
    return (v >> k) | (v << (64 - k));
  endfunction

  // Reference p^n: rounds 12-n..11, S-box looked up column by column.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  o;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int rr = 12 - n; rr < 12; rr++) begin
      x[2][7:0] = x[2][7:0] ^ RC[rr];
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o   = SBOX[col];
        for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s = '0;
    for (int w = 0; w < 10; w++) s = {s[287:0], 32'($urandom)};
    return s;
  endfunction

  task automatic check(input string tag, input int d, input logic [319:0] obs,
                       input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d observed=%h expected=%h", tag, un(d), obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      check({tag, "_ready"}, d, 320'(ready[d]), 320'(1));
      check({tag, "_busy"},  d, 320'(busy[d]),  320'(0));
      check({tag, "_valid"}, d, 320'(valid[d]), 320'(0));
      check({tag, "_err"},   d, 320'(err[d]),   320'(0));
      check({tag, "_state"}, d, so[d], '0);
    end
  endtask

  task automatic run_txn(input logic [319:0] s, input int n);
    logic [319:0] exp;
    int lat  [3];
    int bcnt [3];
    exp = ref_perm(s, n);
    @(negedge clk);
    start = 1'b1; rounds = 4'(n); sin = s;
    @(posedge clk); #1;
    start = 1'b0;
    for (int d = 0; d < 3; d++) begin lat[d] = -1; bcnt[d] = 0; end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      for (int d = 0; d < 3; d++) begin
        if (busy[d]) bcnt[d]++;
        if (valid[d] && lat[d] < 0) lat[d] = cyc;
      end
      if (&valid) break;
    end
    for (int d = 0; d < 3; d++) begin
      check("latency", d, 320'(lat[d]), 320'((n + un(d) - 1) / un(d)));
      check("busy_cycles", d, 320'(bcnt[d]), 320'((n + un(d) - 1) / un(d)));
      check("result", d, so[d], exp);
      held[d] = so[d];
    end
    // Hold ack low in DONE while a competing start is offered.
    @(negedge clk);
    start = 1'b1; rounds = 4'($urandom_range(1, 12)); sin = rand_state();
    repeat (5) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        check("hold_valid", d, 320'(valid[d]), 320'(1));
        check("hold_state", d, so[d], held[d]);
      end
    end
    @(negedge clk);
    start = 1'b0; ack = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      check("ack_ready", d, 320'(ready[d]), 320'(1));
      check("ack_valid", d, 320'(valid[d]), 320'(0));
    end
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic bad_start(input logic [3:0] r);
    @(negedge clk);
    start = 1'b1; rounds = r; sin = rand_state();
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      check("err_pulse", d, 320'(err[d]), 320'(1));
      check("err_ready", d, 320'(ready[d]), 320'(1));
      check("err_state", d, so[d], held[d]);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      check("err_clear", d, 320'(err[d]), 320'(0));
      check("err_idle", d, 320'(ready[d]), 320'(1));
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    repeat (2) @(posedge clk);
    #1 check_reset("reset_held");
    @(negedge clk) rst_n = 1'b1;

    run_txn(VEC, 1);
    run_txn(VEC, 12);
    run_txn(VEC, 6);
    for (int t = 0; t < 6; t++) run_txn(rand_state(), int'($urandom_range(1, 12)));
    run_txn(rand_state(), 5);

    bad_start(4'd0);
    bad_start(4'd13);
    bad_start(4'd15);

    // Reset asserted between edges mid-RUN must clear outputs without a clock.
    @(negedge clk);
    start = 1'b1; rounds = 4'd12; sin = rand_state();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) check("midrun_busy", d, 320'(busy[d]), 320'(1));
    #2 rst_n = 1'b0;
    #1 check_reset("reset_midrun");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
